pixel_rr_arbiter: RTL and testbench
===================================

PIXEL_RR_ARBITER -- requirements
Module: pixel_rr_arbiter

Interface
REQ-001 Parameter ROWS, default 4, pixel rows in the grid (2..16).
REQ-002 Parameter COLS, default 4, pixel columns in the grid (2..16).
REQ-003 Parameter TS_W, default 16, timestamp width (used only under REQ-030).
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-high (despite the name): 1 = reset.
REQ-006 enable  input  1  1 = arbitration permitted to start new row/column selections.
REQ-007 set  input  ROWS*COLS  per-pixel event pulse; bit index = row*COLS + col.
REQ-008 ev_ready  input  1  downstream accepts the presented event.
REQ-009 ev_valid  output  1  registered; an event address is presented.
REQ-010 x_add  output  $clog2(ROWS)  registered row index of the granted pixel.
REQ-011 y_add  output  $clog2(COLS)  registered column index of the granted pixel.
REQ-012 gnt_o  output  ROWS*COLS  one-hot grant, bit row*COLS+col; equals 0 whenever ev_valid=0.
REQ-013 req  output  1  OR of all pending bits (for a higher arbitration level).
REQ-014 grp_release  output  1  one-cycle pulse: last pending event accepted, grid empty.

Function
REQ-015 Pending register (ROWS*COLS bits) shall set bit i on any edge where set[i]=1 (sticky).
REQ-016 Pending bit i shall clear on the edge of the ev_valid&&ev_ready handshake for pixel i, unless set[i]=1 on that same edge (set wins; pixel re-requests).
REQ-017 FSM states: IDLE, ROW_ARB, COL_ARB, GRANT.
REQ-018 IDLE -> ROW_ARB when enable=1 and any pending bit=1; else remain IDLE.
REQ-019 ROW_ARB: select first row with any pending bit, searching circularly from row_ptr+1 (wrap ROWS-1 -> 0); latch it as the active row; -> COL_ARB.
REQ-020 COL_ARB: select first pending column in active row, searching circularly from col_ptr+1; register x_add, y_add, gnt_o; assert ev_valid; -> GRANT.
REQ-021 GRANT: hold ev_valid, x_add, y_add, gnt_o stable until ev_ready=1; no timeout.
REQ-022 On handshake: col_ptr <= y_add; row_ptr <= x_add; ev_valid deasserts next cycle.
REQ-023 After handshake: if enable=1 and the active row has other pending bits (post-update) -> COL_ARB; else if enable=1 and any pending -> ROW_ARB; else -> IDLE.
REQ-024 grp_release shall pulse for exactly the cycle after a handshake that leaves the pending register all-zero (including a simultaneous set: no pulse if set re-fills any bit).
REQ-025 Latency: edge E0 registers set into empty IDLE grid with enable=1; ev_valid=1 after edge E3 (3 edges).
REQ-026 enable dropping during GRANT shall not abort the presented event; FSM goes IDLE after its handshake.
REQ-027 If the active row empties by handshake and no other row pending, FSM goes IDLE; pointers retain values.

Reset
REQ-028 While rst_n=1 on an edge: pending=0, state=IDLE, row_ptr=ROWS-1, col_ptr=COLS-1 (first search starts at 0), ev_valid=0, gnt_o=0, x_add=0, y_add=0, grp_release=0, req=0.
REQ-029 Reset asserted mid-GRANT shall drop the event (no handshake, no grp_release); set on a reset edge is ignored.

Configuration
REQ-030 Macro PIXEL_TIMESTAMP_EN defined: free-running TS_W counter (reset 0, +1 per cycle, wraps to 0); output ev_ts [TS_W-1:0] captured on the COL_ARB->GRANT edge, held stable with ev_valid.
REQ-031 PIXEL_TIMESTAMP_EN undefined: no counter, no ev_ts port; all other behaviour identical.

Verification
REQ-032 4x4, reset, set bit 5 one cycle, ev_ready=1 -> ev_valid after E3 with x_add=1, y_add=1, gnt_o=0x0020; grp_release pulse next cycle; req=0.
REQ-033 set bits 0,1,3 (row 0), ev_ready=1 -> grants (0,0),(0,1),(0,3) in order, one COL_ARB cycle between each, single grp_release after (0,3).
REQ-034 set bits 0 and 4 (rows 0,1), then bit 0 again after first grant -> order (0,0),(1,0),(0,0); row pointer wrap verified.
REQ-035 ev_ready=0 for 10 cycles in GRANT with enable toggled 0 -> outputs stable; after ev_ready=1 FSM goes IDLE although pending remain, req=1.
REQ-036 set[i]=1 on handshake edge of pixel i -> pixel i pending again, no grp_release, later re-granted.
REQ-037 PIXEL_TIMESTAMP_EN defined, set bit 0 at cycle 10 after reset -> ev_ts=12 (COL_ARB->GRANT edge); counter wraps 2^TS_W-1 -> 0.

Source files
------------

// File: rtl/pixel_rr_arbiter.sv
// Round-robin pixel event arbiter: sticky pending grid, row-then-column circular search.
// Optional event timestamping is compiled in with the macro PIXEL_TIMESTAMP_EN.
module pixel_rr_arbiter #(
  parameter int ROWS = 4,
  parameter int COLS = 4,
  parameter int TS_W = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable,
  input  logic [ROWS*COLS-1:0]      set,
  input  logic                      ev_ready,
  output logic                      ev_valid,
  output logic [$clog2(ROWS)-1:0]   x_add,
  output logic [$clog2(COLS)-1:0]   y_add,
  output logic [ROWS*COLS-1:0]      gnt_o,
  output logic                      req,
  output logic                      grp_release
`ifdef PIXEL_TIMESTAMP_EN
  ,
  output logic [TS_W-1:0]           ev_ts
`endif
);
  localparam int N  = ROWS * COLS;
  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);

  if (ROWS < 2 || ROWS > 16 || COLS < 2 || COLS > 16 || TS_W < 1) begin : g_param_check
    $error("pixel_rr_arbiter: parameter out of range");
  end

  typedef enum logic [1:0] {IDLE, ROW_ARB, COL_ARB, GRANT} state_t;

  state_t          state_reg, state_next;
  logic [N-1:0]    pending_reg, pending_next, clear_mask;
  logic [N-1:0]    gnt_reg, gnt_next;
  logic [RW-1:0]   row_ptr_reg, active_row_reg, x_add_reg, row_sel, ridx;
  logic [CW-1:0]   col_ptr_reg, y_add_reg, col_sel, cidx;
  logic            ev_valid_reg, grp_release_reg;
  logic            row_found, col_found, handshake;
  logic [ROWS-1:0] row_any;
  logic [COLS-1:0] row_bits [ROWS];
  logic [COLS-1:0] row_bits_next [ROWS];
  logic [COLS-1:0] active_bits, active_bits_next;

  assign handshake    = (state_reg == GRANT) && ev_valid_reg && ev_ready;
  assign clear_mask   = handshake ? gnt_reg : '0;
  // A set arriving on the handshake edge re-arms the pixel being retired.
  assign pending_next = (pending_reg & ~clear_mask) | set;

  for (genvar gi = 0; gi < ROWS; gi++) begin : g_rows
    assign row_bits[gi]      = pending_reg[gi*COLS +: COLS];
    assign row_bits_next[gi] = pending_next[gi*COLS +: COLS];
    assign row_any[gi]       = |row_bits[gi];
  end

  assign active_bits      = row_bits[active_row_reg];
  assign active_bits_next = row_bits_next[active_row_reg];

  for (genvar gi = 0; gi < N; gi++) begin : g_gnt
    assign gnt_next[gi] = (active_row_reg == RW'(gi / COLS)) && (col_sel == CW'(gi % COLS));
  end

  // Circular searches start one past the last granted row/column.
  always_comb begin
    row_found = 1'b0;
    row_sel   = '0;
    ridx      = '0;
    for (int k = 1; k <= ROWS; k++) begin
      ridx = RW'((int'(row_ptr_reg) + k) % ROWS);
      if (!row_found && row_any[ridx]) begin
        row_found = 1'b1;
        row_sel   = ridx;
      end
    end
  end

  always_comb begin
    col_found = 1'b0;
    col_sel   = '0;
    cidx      = '0;
    for (int k = 1; k <= COLS; k++) begin
      cidx = CW'((int'(col_ptr_reg) + k) % COLS);
      if (!col_found && active_bits[cidx]) begin
        col_found = 1'b1;
        col_sel   = cidx;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE:    if (enable && (|pending_reg)) state_next = ROW_ARB;
      ROW_ARB: state_next = row_found ? COL_ARB : IDLE;
      COL_ARB: state_next = col_found ? GRANT : IDLE;
      GRANT: begin
        if (ev_ready) begin
          if (enable && (|active_bits_next))  state_next = COL_ARB;
          else if (enable && (|pending_next)) state_next = ROW_ARB;
          else                                state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_reg       <= IDLE;
      pending_reg     <= '0;
      row_ptr_reg     <= RW'(ROWS - 1);
      col_ptr_reg     <= CW'(COLS - 1);
      active_row_reg  <= '0;
      ev_valid_reg    <= 1'b0;
      x_add_reg       <= '0;
      y_add_reg       <= '0;
      gnt_reg         <= '0;
      grp_release_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      pending_reg     <= pending_next;
      grp_release_reg <= handshake && (pending_next == '0);
      if (state_reg == ROW_ARB && row_found) active_row_reg <= row_sel;
      if (state_reg == COL_ARB && col_found) begin
        ev_valid_reg <= 1'b1;
        x_add_reg    <= active_row_reg;
        y_add_reg    <= col_sel;
        gnt_reg      <= gnt_next;
      end else if (handshake) begin
        ev_valid_reg <= 1'b0;
        gnt_reg      <= '0;
        row_ptr_reg  <= x_add_reg;
        col_ptr_reg  <= y_add_reg;
      end
    end
  end

`ifdef PIXEL_TIMESTAMP_EN
  logic [TS_W-1:0] ts_cnt_reg, ev_ts_reg;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      ts_cnt_reg <= '0;
      ev_ts_reg  <= '0;
    end else begin
      ts_cnt_reg <= ts_cnt_reg + 1'b1;
      if (state_reg == COL_ARB && col_found) ev_ts_reg <= ts_cnt_reg;
    end
  end

  assign ev_ts = ev_ts_reg;
`endif

  assign ev_valid    = ev_valid_reg;
  assign x_add       = x_add_reg;
  assign y_add       = y_add_reg;
  assign gnt_o       = gnt_reg;
  assign req         = |pending_reg;
  assign grp_release = grp_release_reg;

endmodule

// File: tb/tb_pixel_rr_arbiter.sv
// Scoreboard bench for pixel_rr_arbiter (4x4): directed scenarios push expected grants,
// a negedge monitor pops and compares them at every handshake.
module tb_pixel_rr_arbiter;
  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam int TS_W = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [15:0] set;
  logic        ev_ready;
  logic        ev_valid;
  logic [1:0]  x_add;
  logic [1:0]  y_add;
  logic [15:0] gnt_o;
  logic        req;
  logic        grp_release;
`ifdef PIXEL_TIMESTAMP_EN
  logic [TS_W-1:0] ev_ts;
`endif

  pixel_rr_arbiter #(.ROWS(ROWS), .COLS(COLS), .TS_W(TS_W)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .set(set), .ev_ready(ev_ready),
    .ev_valid(ev_valid), .x_add(x_add), .y_add(y_add), .gnt_o(gnt_o),
    .req(req), .grp_release(grp_release)
`ifdef PIXEL_TIMESTAMP_EN
    , .ev_ts(ev_ts)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int          x;
    int          y;
    logic [15:0] g;
  } exp_t;

  exp_t exp_q[$];
  int   hs_cyc[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   hs_count = 0;
  int   grp_cnt  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req_v);
    n_checks++;
    if (act !== req_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req_v, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: one line per accepted event.
  always @(negedge clk) begin
    if (!rst_n) begin
      if (grp_release) grp_cnt++;
      if (!ev_valid) check("gnt_idle_zero", 32'(gnt_o), 32'h0);
      if (ev_valid && ev_ready) begin
        hs_count++;
        hs_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          check("unexpected_grant", 32'(gnt_o), 32'h0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          $display("event x=%0d y=%0d gnt=0x%04h (expected x=%0d y=%0d gnt=0x%04h)",
                   x_add, y_add, gnt_o, e.x, e.y, e.g);
          check("x_add", 32'(x_add), 32'(e.x));
          check("y_add", 32'(y_add), 32'(e.y));
          check("gnt_o", 32'(gnt_o), 32'(e.g));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int x, input int y, input logic [15:0] g);
    exp_t e;
    e.x = x; e.y = y; e.g = g;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    rst_n = 1'b1; set = '0; enable = 1'b0; ev_ready = 1'b0;
    tick(); tick();
    rst_n = 1'b0;
    exp_q.delete(); hs_cyc.delete();
    hs_count = 0; grp_cnt = 0;
    check("rst_ev_valid", 32'(ev_valid), 32'h0);
    check("rst_gnt", 32'(gnt_o), 32'h0);
    check("rst_xy", 32'({x_add, y_add}), 32'h0);
    check("rst_grp_req", 32'({grp_release, req}), 32'h0);
  endtask

  task automatic drain(input int bound);
    for (int i = 0; i < bound && exp_q.size() != 0; i++) tick();
    check("drain_timeout", 32'(exp_q.size()), 32'h0);
    tick(); tick();
  endtask

  initial begin
    rst_n = 1'b1; set = '0; enable = 1'b0; ev_ready = 1'b0;

    // Single event at (1,1): 3-edge latency, release pulse after handshake.
    do_reset();
    enable = 1'b1; ev_ready = 1'b1;
    push(1, 1, 16'h0020);
    set = 16'h0020; tick(); set = '0;
    tick(); tick();
    check("lat_e2_not_valid", 32'(ev_valid), 32'h0);
    tick();
    check("lat_e3_valid", 32'(ev_valid), 32'h1);
    tick();
    check("t1_grp_pulse", 32'(grp_release), 32'h1);
    check("t1_req", 32'(req), 32'h0);
    check("t1_valid_drop", 32'(ev_valid), 32'h0);
    tick();
    check("t1_grp_one_cycle", 32'(grp_release), 32'h0);

    // Three pixels in row 0 granted in column order, one COL_ARB cycle apart.
    do_reset();
    enable = 1'b1; ev_ready = 1'b1;
    push(0, 0, 16'h0001); push(0, 1, 16'h0002); push(0, 3, 16'h0008);
    set = 16'h000B; tick(); set = '0;
    drain(50);
    check("t2_hs_count", 32'(hs_cyc.size()), 32'd3);
    if (hs_cyc.size() == 3) begin
      check("t2_gap01", 32'(hs_cyc[1] - hs_cyc[0]), 32'd2);
      check("t2_gap12", 32'(hs_cyc[2] - hs_cyc[1]), 32'd2);
    end
    check("t2_grp_count", 32'(grp_cnt), 32'd1);

    // Rows 0 and 1, then row 0 again: row pointer wraps.
    do_reset();
    enable = 1'b1; ev_ready = 1'b1;
    push(0, 0, 16'h0001); push(1, 0, 16'h0010); push(0, 0, 16'h0001);
    set = 16'h0011; tick(); set = '0;
    for (int i = 0; i < 20 && hs_count < 1; i++) tick();
    set = 16'h0001; tick(); set = '0;
    drain(50);
    check("t3_grp_count", 32'(grp_cnt), 32'd1);

    // Stalled grant with enable dropped: stable outputs, then IDLE with work pending.
    do_reset();
    enable = 1'b1; ev_ready = 1'b0;
    set = 16'h0204; tick(); set = '0;
    tick(); tick(); tick();
    enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check("t4_stable", {13'h0, ev_valid, x_add, y_add, gnt_o}, {13'h0, 1'b1, 2'd0, 2'd2, 16'h0004});
      tick();
    end
    push(0, 2, 16'h0004);
    ev_ready = 1'b1; tick(); ev_ready = 1'b0;
    tick(); tick(); tick();
    check("t4_idle_no_valid", 32'(ev_valid), 32'h0);
    check("t4_req_pending", 32'(req), 32'h1);
    check("t4_no_grp", 32'(grp_cnt), 32'h0);
    check("t4_popped", 32'(exp_q.size()), 32'h0);
    push(2, 1, 16'h0200);
    enable = 1'b1; ev_ready = 1'b1;
    drain(50);
    check("t4_grp_count", 32'(grp_cnt), 32'd1);

    // Re-set on the handshake edge re-arms the pixel.
    do_reset();
    enable = 1'b1; ev_ready = 1'b1;
    push(1, 2, 16'h0040); push(1, 2, 16'h0040);
    set = 16'h0040; tick(); set = '0;
    tick(); tick(); tick();
    set = 16'h0040; tick(); set = '0;
    check("t5_no_grp", 32'(grp_release), 32'h0);
    check("t5_req", 32'(req), 32'h1);
    drain(50);
    check("t5_grp_count", 32'(grp_cnt), 32'd1);

    // Reset during GRANT drops the event; set on the reset edge is ignored.
    do_reset();
    enable = 1'b1; ev_ready = 1'b0;
    set = 16'h8000; tick(); set = '0;
    tick(); tick(); tick();
    check("t6_valid_before_rst", 32'(ev_valid), 32'h1);
    check("t6_gnt_before_rst", 32'(gnt_o), 32'h8000);
    rst_n = 1'b1; set = 16'h0001; tick(); set = '0; rst_n = 1'b0;
    ev_ready = 1'b1;
    tick(); tick(); tick(); tick();
    check("t6_valid_after_rst", 32'(ev_valid), 32'h0);
    check("t6_req_after_rst", 32'(req), 32'h0);
    check("t6_no_grp", 32'(grp_cnt), 32'h0);

    check("final_queue_empty", 32'(exp_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end
endmodule
